sr_cmd_conditioner: RTL and testbench
=====================================

Name: sr_cmd_conditioner

Overview:
- Upstream stage for the SR flip-flop.
- Takes two raw, asynchronous, possibly bouncing request lines (set request, reset request) and synchronises and debounces each one.
- Arbitrates them into a clean 2-bit SR command on clk, encoded sr[1]=S, sr[0]=R: 00 hold, 01 reset, 10 set.
- Never emits the illegal code 11; detects conflicts, flags them and counts them.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive sampled edges a synchronised input must differ from its stable value before the stable value flips (legal range 1..255).
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_raw  input  1  raw set request, asynchronous to clk.
- r_raw  input  1  raw reset request, asynchronous to clk.
- sr  output  2  registered SR command to the flip-flop stage: 00/01/10 only.
- conflict  output  1  registered, high while the FSM is in CONFLICT.
- conflict_cnt  output  CNT_W  number of CONFLICT entries, saturating at all-ones.

Behaviour:
- Reset (async, rst=1): sync flops=0, stable values=0, debounce counters=0, FSM=IDLE, sr=2'b00, conflict=0, conflict_cnt=0. Outputs take these values immediately on rst assertion, independent of clk. Reset mid-debounce discards partial counts.
- Synchroniser: 2-flop chain per input (s_sync, r_sync).
- Debounce, per channel with an independent counter:
  - When sync != stable, the counter increments each edge.
  - When sync == stable, the counter clears to 0 on that edge.
  - When the counter reaches DEBOUNCE_CYCLES-1 and sync != stable still holds, stable <= sync and the counter clears, on the same edge.
- Latency: a raw change first sampled at edge 1 reaches stable at edge 2+DEBOUNCE_CYCLES and sr at edge 3+DEBOUNCE_CYCLES (edge 7 at default).
- Any pulse or glitch shorter than DEBOUNCE_CYCLES synchronised cycles is rejected entirely.
- FSM (registered; inputs are the stable values {s_st, r_st}):
  - IDLE (sr=00): 10->SET; 01->RST; 11->CONFLICT; 00 stay.
  - SET (sr=10): 00->IDLE; 01->RST; 11->CONFLICT; 10 stay.
  - RST (sr=01): 00->IDLE; 10->SET; 11->CONFLICT; 01 stay.
  - CONFLICT (sr=00, conflict=1): 00->IDLE only. Otherwise stay (lockout): releasing one request does not issue the other.
- sr and conflict are Moore outputs registered with the state, so they change on the same edge as the state.
- Simultaneous stable flips on both channels in one edge are evaluated as one combined input. 00->11 goes directly to CONFLICT; 11->00 leaves CONFLICT for IDLE.
- conflict_cnt increments by 1 on each edge where the FSM enters CONFLICT from a non-CONFLICT state. It holds at 2^CNT_W-1 once reached, with no wrap.
- sr is never 11 in any state or during reset.

Optional Feature:
- Macro SR_CMD_PULSE_EN.
- Defined: SET and RST become one-shot states.
  - On entry, sr carries 10/01 for exactly one cycle.
  - The FSM then moves to a HOLD state (sr=00) and remains there while the same stable request persists.
  - HOLD transitions are identical to the originating state's transitions: 00->IDLE, opposite request->its state, 11->CONFLICT.
  - Re-issue requires release to 00 or switching to the opposite request.
- Undefined: level mode as above; sr holds 10/01 for as long as the stable request persists.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=8, level mode unless stated):
- Reset: assert rst mid-cycle with s_raw=1 held long -> sr=00, conflict=0, conflict_cnt=0 immediately. After release, sr=10 at the 7th edge after s_raw is first sampled.
- Bounce rejection: s_raw high for 3 cycles, low 1, high 3, low -> sr stays 00 throughout. s_raw then held high 10 cycles -> sr=10 exactly 7 edges after the final rise is sampled.
- Set->reset handover: s_raw high (sr=10), then s_raw low and r_raw high on the same cycle -> single transition to sr=01 at +7 edges, with no intermediate 11. 00 is allowed for at most 0 cycles because both flips land on the same edge.
- Conflict lockout: s_raw high (sr=10), then r_raw high -> sr=00, conflict=1, conflict_cnt=1. Drop s_raw only -> remains CONFLICT, sr=00. Drop r_raw -> IDLE, conflict=0.
- Counter saturation: force 260 conflict entry/exit cycles -> conflict_cnt reads 255 and stays at 255.
- With SR_CMD_PULSE_EN defined: r_raw held high 20 cycles -> sr=01 for exactly one cycle, then 00. Release and re-press -> exactly one more 01 pulse.

Source files
------------

// File: rtl/sr_cmd_conditioner_if.sv
// sr_cmd_conditioner_if: raw request lines in, conditioned SR command, conflict flag and conflict count out.
interface sr_cmd_conditioner_if #(parameter int CNT_W = 8);
  logic             s_raw;
  logic             r_raw;
  logic [1:0]       sr;
  logic             conflict;
  logic [CNT_W-1:0] conflict_cnt;
  modport master (output s_raw, r_raw, input sr, conflict, conflict_cnt);
  modport slave  (input s_raw, r_raw, output sr, conflict, conflict_cnt);
endinterface

// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner: synchronise, debounce and arbitrate raw set/reset requests into a legal SR command.
// Define SR_CMD_PULSE_EN for one-shot SET/RST commands; otherwise sr follows the stable request level.
module sr_cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  sr_cmd_conditioner_if.slave cmd
);
  typedef enum logic [2:0] {IDLE, SET, RST, CONF, HSET, HRST} state_t;
  state_t           state_q, state_d;
  logic [1:0]       s_sync_q, r_sync_q;
  logic [1:0]       sy;
  logic [1:0]       st_q, st_d;
  logic [1:0][7:0]  cnt_q, cnt_d;
  logic [1:0]       sr_q, sr_d;
  logic             conf_q;
  logic [CNT_W-1:0] ccnt_q;
  assign sy = {s_sync_q[1], r_sync_q[1]};
  always_comb begin
    st_d  = st_q;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = (sy[i] != st_q[i] && cnt_q[i] == 8'(DEBOUNCE_CYCLES - 1)) ? sy[i] : st_q[i];
      cnt_d[i] = (sy[i] != st_q[i] && cnt_q[i] != 8'(DEBOUNCE_CYCLES - 1)) ? cnt_q[i] + 8'd1 : 8'd0;
    end
  end
  // CONFLICT is a lockout: only a full release (00) leaves it
  always_comb begin
    state_d = state_q;
    if (st_q == 2'b11) state_d = CONF;
    else if (st_q == 2'b00) state_d = IDLE;
    else if (state_q != CONF) begin
`ifdef SR_CMD_PULSE_EN
      if (st_q[1]) state_d = (state_q == SET || state_q == HSET) ? HSET : SET;
      else state_d = (state_q == RST || state_q == HRST) ? HRST : RST;
`else
      state_d = st_q[1] ? SET : RST;
`endif
    end
  end
  assign sr_d = (state_d == SET) ? 2'b10 : (state_d == RST) ? 2'b01 : 2'b00;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_sync_q <= '0;
      r_sync_q <= '0;
      st_q     <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      sr_q     <= 2'b00;
      conf_q   <= 1'b0;
      ccnt_q   <= '0;
    end else begin
      s_sync_q <= {s_sync_q[0], cmd.s_raw};
      r_sync_q <= {r_sync_q[0], cmd.r_raw};
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      sr_q     <= sr_d;
      conf_q   <= (state_d == CONF);
      if (state_d == CONF && state_q != CONF && !(&ccnt_q)) ccnt_q <= ccnt_q + 1'b1;
    end
  end
  assign cmd.sr           = sr_q;
  assign cmd.conflict     = conf_q;
  assign cmd.conflict_cnt = ccnt_q;
endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// tb_sr_cmd_conditioner: directed scenarios plus random request traffic against a behavioural model.
module tb_sr_cmd_conditioner;
  localparam int DC = 4;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  sr_cmd_conditioner_if #(.CNT_W(CW)) bus ();
  sr_cmd_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .cmd(bus));
  logic [1:0] samp[$];
  logic [1:0] m_st, m_prev, m_sr;
  int         run[2];
  bit         m_lock;
  int         m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      samp = {2'b00, 2'b00};
      m_st = 2'b00; m_prev = 2'b00; m_sr = 2'b00;
      run[0] = 0; run[1] = 0;
      m_lock = 0; m_cnt = 0;
    end else begin
      logic [1:0] sync;
      if (m_st == 2'b11) begin
        if (!m_lock && m_cnt < 255) m_cnt++;
        m_lock = 1;
      end else if (m_st == 2'b00) m_lock = 0;
`ifdef SR_CMD_PULSE_EN
      m_sr = (m_lock || m_st == 2'b00 || m_st == 2'b11 || m_st == m_prev) ? 2'b00 : m_st;
`else
      m_sr = (m_lock || m_st == 2'b11) ? 2'b00 : m_st;
`endif
      m_prev = m_st;
      sync = samp[samp.size() - 2];
      for (int i = 0; i < 2; i++) begin
        run[i] = (sync[i] != m_st[i]) ? run[i] + 1 : 0;
        if (run[i] == DC) begin
          m_st[i] = sync[i];
          run[i] = 0;
        end
      end
      samp.push_back({bus.s_raw, bus.r_raw});
      if (samp.size() > 4) void'(samp.pop_front());
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    check("sr", 32'(bus.sr), 32'(m_sr));
    check("conflict", 32'(bus.conflict), 32'(m_lock));
    check("cnt", 32'(bus.conflict_cnt), m_cnt);
    check("sr_legal", 32'(bus.sr == 2'b11), 0);
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic latency(input string tag, input logic [1:0] want, input int exp_edges);
    int n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (n == 0 && bus.sr == want) n = i;
    end
    check(tag, n, exp_edges);
  endtask
  initial begin
    int c0, zeros, pulses;
    rst = 1'b1; bus.s_raw = 1'b0; bus.r_raw = 1'b0;
    #12;
    check("rst_sr", 32'(bus.sr), 0);
    check("rst_conflict", 32'(bus.conflict), 0);
    check("rst_cnt", 32'(bus.conflict_cnt), 0);
    @(negedge clk); rst = 1'b0;
    steps(3);
    bus.s_raw = 1'b1;
    latency("first_set_latency", 2'b10, 7);
    @(posedge clk); #2 rst = 1'b1; #1;
    check("async_rst_sr", 32'(bus.sr), 0);
    check("async_rst_conflict", 32'(bus.conflict), 0);
    check("async_rst_cnt", 32'(bus.conflict_cnt), 0);
    @(negedge clk); rst = 1'b0;
    latency("post_rst_latency", 2'b10, 7);
    bus.s_raw = 1'b0; steps(12);
    bus.s_raw = 1'b1; steps(3);
    bus.s_raw = 1'b0; steps(1);
    bus.s_raw = 1'b1; steps(3);
    bus.s_raw = 1'b0; steps(10);
    check("bounce_sr", 32'(bus.sr), 0);
    bus.s_raw = 1'b1;
    latency("bounce_final_latency", 2'b10, 7);
    zeros = 0;
    bus.s_raw = 1'b0; bus.r_raw = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i < 7 && bus.sr == 2'b00) zeros++;
    end
    check("handover_sr", 32'(bus.sr), 32'(2'b01));
`ifndef SR_CMD_PULSE_EN
    check("handover_no_gap", zeros, 0);
`endif
    bus.r_raw = 1'b0; steps(12);
    c0 = int'(bus.conflict_cnt);
    bus.s_raw = 1'b1; steps(10);
    bus.r_raw = 1'b1; steps(10);
    check("lock_conflict", 32'(bus.conflict), 1);
    check("lock_sr", 32'(bus.sr), 0);
    check("lock_cnt", 32'(bus.conflict_cnt), c0 + 1);
    bus.s_raw = 1'b0; steps(10);
    check("lock_hold_conflict", 32'(bus.conflict), 1);
    check("lock_hold_sr", 32'(bus.sr), 0);
    bus.r_raw = 1'b0; steps(10);
    check("lock_exit_conflict", 32'(bus.conflict), 0);
`ifdef SR_CMD_PULSE_EN
    pulses = 0;
    bus.r_raw = 1'b1;
    for (int i = 0; i < 20; i++) begin step(); if (bus.sr == 2'b01) pulses++; end
    check("pulse_first", pulses, 1);
    bus.r_raw = 1'b0; steps(10);
    pulses = 0;
    bus.r_raw = 1'b1;
    for (int i = 0; i < 20; i++) begin step(); if (bus.sr == 2'b01) pulses++; end
    check("pulse_second", pulses, 1);
    bus.r_raw = 1'b0; steps(10);
`endif
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(3) == 0) bus.s_raw = ~bus.s_raw;
      if ($urandom_range(3) == 0) bus.r_raw = ~bus.r_raw;
      steps($urandom_range(1, 8));
    end
    bus.s_raw = 1'b0; bus.r_raw = 1'b0; steps(10);
    for (int k = 0; k < 260; k++) begin
      bus.s_raw = 1'b1; bus.r_raw = 1'b1; steps(8);
      bus.s_raw = 1'b0; bus.r_raw = 1'b0; steps(8);
    end
    check("cnt_saturated", 32'(bus.conflict_cnt), 255);
    bus.s_raw = 1'b1; bus.r_raw = 1'b1; steps(10);
    check("cnt_stays_saturated", 32'(bus.conflict_cnt), 255);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
